// File: rtl/mux_arbiter.sv
// Two-requester round-robin arbiter that drives a shared, registered data mux.
// An owner that holds the mux for MAX_HOLD cycles while the other side waits is forced off.
module mux_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             sel_o,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic             timeout
);

    localparam int            CW       = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);
    localparam logic [CW-1:0] HOLD_ONE = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT_A,
        GRANT_B
    } state_t;

    state_t            r_state;
    state_t            w_stateNext;
    logic              r_last;
    logic              w_lastNext;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cntNext;
    logic              r_sel;
    logic              w_selNext;
    logic              r_timeout;
    logic              w_timeoutNext;
    logic [WIDTH-1:0]  r_q;
    logic              r_valid;

    // r_last = 1 means B held the mux most recently, so A wins the next contention.
    always_comb begin
        w_stateNext   = r_state;
        w_timeoutNext = 1'b0;
        w_cntNext     = r_cnt;
        w_lastNext    = r_last;
        w_selNext     = r_sel;

        unique case (r_state)
            IDLE: begin
                if (req_a && (!req_b || r_last)) begin
                    w_stateNext = GRANT_A;
                end else if (req_b) begin
                    w_stateNext = GRANT_B;
                end
            end
            GRANT_A: begin
                if (!req_a) begin
                    w_stateNext = req_b ? GRANT_B : IDLE;
                end else if (req_b && (r_cnt == HOLD_MAX)) begin
                    w_stateNext   = GRANT_B;
                    w_timeoutNext = 1'b1;
                end
            end
            GRANT_B: begin
                if (!req_b) begin
                    w_stateNext = req_a ? GRANT_A : IDLE;
                end else if (req_a && (r_cnt == HOLD_MAX)) begin
                    w_stateNext   = GRANT_A;
                    w_timeoutNext = 1'b1;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase

        // A new owner restarts the hold count; sel only moves when ownership changes.
        if (w_stateNext == IDLE) begin
            w_cntNext = '0;
        end else if (w_stateNext != r_state) begin
            w_cntNext  = HOLD_ONE;
            w_lastNext = (w_stateNext == GRANT_B);
            w_selNext  = (w_stateNext == GRANT_B);
        end else if (r_cnt != HOLD_MAX) begin
            w_cntNext = r_cnt + HOLD_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_last    <= 1'b1;
            r_cnt     <= '0;
            r_sel     <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_last    <= w_lastNext;
            r_cnt     <= w_cntNext;
            r_sel     <= w_selNext;
            r_timeout <= w_timeoutNext;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= (r_state != IDLE);
            if (r_state != IDLE) begin
                r_q <= r_sel ? b : a;
            end
        end
    end

    assign gnt_a   = (r_state == GRANT_A);
    assign gnt_b   = (r_state == GRANT_B);
    assign sel_o   = r_sel;
    assign q       = r_q;
    assign valid   = r_valid;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_mux_arbiter.sv
// Bench for mux_arbiter: a reference model pushes expected outputs per clock into a
// scoreboard queue, a monitor pops and compares them, and each scenario adds its own checks.
module tb_mux_arbiter;

    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 8;

    logic             clk;
    logic             rstN;
    logic             reqA;
    logic             reqB;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic             gntA;
    logic             gntB;
    logic             selO;
    logic [WIDTH-1:0] qOut;
    logic             validOut;
    logic             timeoutOut;

    int nChecks = 0;
    int nPass   = 0;

    typedef struct {
        logic             gntA;
        logic             gntB;
        logic             sel;
        logic [WIDTH-1:0] q;
        logic             valid;
        logic             timeout;
    } exp_t;

    exp_t sbQ[$];

    // Reference model state: 0 idle, 1 A owns, 2 B owns; mLast 1 means B owned last.
    int               mState;
    bit               mLast;
    int               mCnt;
    bit               mSel;
    logic [WIDTH-1:0] mQ;
    bit               mValid;
    bit               mTimeout;

    mux_arbiter #(
        .WIDTH    (WIDTH),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk     (clk),
        .reset   (rstN),
        .req_a   (reqA),
        .req_b   (reqB),
        .a       (dataA),
        .b       (dataB),
        .gnt_a   (gntA),
        .gnt_b   (gntB),
        .sel_o   (selO),
        .q       (qOut),
        .valid   (validOut),
        .timeout (timeoutOut)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic modelReset();
        mState   = 0;
        mLast    = 1'b1;
        mCnt     = 0;
        mSel     = 1'b0;
        mQ       = '0;
        mValid   = 1'b0;
        mTimeout = 1'b0;
    endtask

    // Predicts the outputs after the coming rising edge and queues them.
    task automatic modelStep(input logic ra, input logic rb,
                             input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db);
        int   nState;
        bit   forced;
        exp_t e;
        if (!rstN) begin
            modelReset();
        end else begin
            if (mState != 0) mQ = mSel ? db : da;
            mValid = (mState != 0);
            nState = mState;
            forced = 1'b0;
            if (mState == 0) begin
                if (ra && rb)  nState = mLast ? 1 : 2;
                else if (ra)   nState = 1;
                else if (rb)   nState = 2;
            end else begin
                logic own, other;
                own   = (mState == 1) ? ra : rb;
                other = (mState == 1) ? rb : ra;
                if (!own) begin
                    nState = other ? (3 - mState) : 0;
                end else if (other && mCnt >= MAX_HOLD) begin
                    nState = 3 - mState;
                    forced = 1'b1;
                end
            end
            if (nState == 0) begin
                mCnt = 0;
            end else if (nState != mState) begin
                mCnt  = 1;
                mLast = (nState == 2);
                mSel  = (nState == 2);
            end else if (mCnt < MAX_HOLD) begin
                mCnt = mCnt + 1;
            end
            mState   = nState;
            mTimeout = forced;
        end
        e.gntA    = (mState == 1);
        e.gntB    = (mState == 2);
        e.sel     = mSel;
        e.q       = mQ;
        e.valid   = mValid;
        e.timeout = mTimeout;
        sbQ.push_back(e);
    endtask

    // Drives one cycle of inputs on the falling edge and returns 2 time units after the rising edge.
    task automatic applyStimulus(input logic ra, input logic rb,
                                 input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db);
        @(negedge clk);
        reqA  = ra;
        reqB  = rb;
        dataA = da;
        dataB = db;
        modelStep(ra, rb, da, db);
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            nChecks++;
            if (gntA !== e.gntA) $display("[TB] FAIL sb_gnt_a: got %b required %b", gntA, e.gntA);
            else nPass++;
            nChecks++;
            if (gntB !== e.gntB) $display("[TB] FAIL sb_gnt_b: got %b required %b", gntB, e.gntB);
            else nPass++;
            nChecks++;
            if (selO !== e.sel) $display("[TB] FAIL sb_sel_o: got %b required %b", selO, e.sel);
            else nPass++;
            nChecks++;
            if (qOut !== e.q) $display("[TB] FAIL sb_q: got %h required %h", qOut, e.q);
            else nPass++;
            nChecks++;
            if (validOut !== e.valid) $display("[TB] FAIL sb_valid: got %b required %b", validOut, e.valid);
            else nPass++;
            nChecks++;
            if (timeoutOut !== e.timeout) $display("[TB] FAIL sb_timeout: got %b required %b", timeoutOut, e.timeout);
            else nPass++;
            nChecks++;
            if (gntA && gntB) $display("[TB] FAIL sb_exclusive: got both grants high required at most one");
            else nPass++;
        end
    end

    task automatic test_reset();
        #2;
        nChecks++;
        if ({gntA, gntB, selO, validOut, timeoutOut, qOut} !== 13'd0)
            $display("[TB] FAIL reset_values: got %b required 0", {gntA, gntB, selO, validOut, timeoutOut, qOut});
        else nPass++;
        applyStimulus(1'b1, 1'b0, 8'h5A, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h5A, 8'h00);
        rstN = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'h5A, 8'h00);
        nChecks++;
        if (gntA !== 1'b1 || selO !== 1'b0)
            $display("[TB] FAIL release_grant: got gnt_a=%b sel_o=%b required gnt_a=1 sel_o=0", gntA, selO);
        else nPass++;
        applyStimulus(1'b1, 1'b0, 8'h5A, 8'h00);
        nChecks++;
        if (qOut !== 8'h5A || validOut !== 1'b1)
            $display("[TB] FAIL release_data: got q=%h valid=%b required q=5a valid=1", qOut, validOut);
        else nPass++;
    endtask

    task automatic test_handoff();
        #1 rstN = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h11, 8'h22);
        rstN = 1'b1;
        applyStimulus(1'b1, 1'b1, 8'h11, 8'h22);
        nChecks++;
        if (gntA !== 1'b1 || gntB !== 1'b0)
            $display("[TB] FAIL contention_first: got gnt_a=%b gnt_b=%b required 1 0", gntA, gntB);
        else nPass++;
        applyStimulus(1'b0, 1'b1, 8'h11, 8'h22);
        nChecks++;
        if (gntB !== 1'b1 || gntA !== 1'b0 || selO !== 1'b1)
            $display("[TB] FAIL handoff: got gnt_a=%b gnt_b=%b sel_o=%b required 0 1 1", gntA, gntB, selO);
        else nPass++;
        applyStimulus(1'b0, 1'b1, 8'h11, 8'h22);
        nChecks++;
        if (qOut !== 8'h22 || validOut !== 1'b1)
            $display("[TB] FAIL handoff_data: got q=%h valid=%b required q=22 valid=1", qOut, validOut);
        else nPass++;
    endtask

    task automatic test_timeout();
        int aCount;
        int bCount;
        int toCount;
        bit toOnSwitch;
        aCount     = 0;
        bCount     = 0;
        toCount    = 0;
        toOnSwitch = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h33, 8'h44);
        applyStimulus(1'b0, 1'b0, 8'h33, 8'h44);
        applyStimulus(1'b1, 1'b0, 8'h33, 8'h44);
        if (gntA) aCount++;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 1'b1, 8'h33, 8'h44);
            if (gntA) aCount++;
            if (gntB) begin
                if (bCount == 0 && timeoutOut) toOnSwitch = 1'b1;
                bCount++;
            end
            if (timeoutOut) toCount++;
        end
        nChecks++;
        if (aCount !== MAX_HOLD) $display("[TB] FAIL hold_len: got %0d cycles required %0d", aCount, MAX_HOLD);
        else nPass++;
        nChecks++;
        if (bCount !== 5) $display("[TB] FAIL after_switch: got %0d gnt_b cycles required 5", bCount);
        else nPass++;
        nChecks++;
        if (toCount !== 1 || !toOnSwitch)
            $display("[TB] FAIL timeout_pulse: got %0d pulses on_switch=%b required 1 on_switch=1", toCount, toOnSwitch);
        else nPass++;
    endtask

    task automatic test_saturate();
        int bCount;
        int toCount;
        bCount  = 0;
        toCount = 0;
        applyStimulus(1'b0, 1'b0, 8'h99, 8'hB7);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b1, 8'h99, 8'hB7);
            if (gntB) bCount++;
            if (timeoutOut) toCount++;
        end
        nChecks++;
        if (bCount !== 20) $display("[TB] FAIL saturate_hold: got %0d gnt_b cycles required 20", bCount);
        else nPass++;
        nChecks++;
        if (toCount !== 0) $display("[TB] FAIL saturate_timeout: got %0d pulses required 0", toCount);
        else nPass++;
    endtask

    task automatic test_idle_hold();
        applyStimulus(1'b0, 1'b0, 8'h99, 8'hB7);
        applyStimulus(1'b0, 1'b0, 8'h99, 8'h44);
        nChecks++;
        if (validOut !== 1'b0 || qOut !== 8'hB7 || selO !== 1'b1)
            $display("[TB] FAIL idle_hold: got valid=%b q=%h sel_o=%b required 0 b7 1", validOut, qOut, selO);
        else nPass++;
        applyStimulus(1'b0, 1'b0, 8'h12, 8'h34);
        nChecks++;
        if (qOut !== 8'hB7 || gntA !== 1'b0 || gntB !== 1'b0)
            $display("[TB] FAIL idle_stay: got q=%h gnt_a=%b gnt_b=%b required b7 0 0", qOut, gntA, gntB);
        else nPass++;
    endtask

    task automatic test_reset_mid_grant();
        applyStimulus(1'b0, 1'b1, 8'h61, 8'h62);
        applyStimulus(1'b1, 1'b1, 8'h61, 8'h62);
        nChecks++;
        if (gntB !== 1'b1) $display("[TB] FAIL mid_setup: got gnt_b=%b required 1", gntB);
        else nPass++;
        #1 rstN = 1'b0;
        #1;
        nChecks++;
        if ({gntA, gntB, selO, validOut, timeoutOut, qOut} !== 13'd0)
            $display("[TB] FAIL async_reset: got %b required 0", {gntA, gntB, selO, validOut, timeoutOut, qOut});
        else nPass++;
        applyStimulus(1'b1, 1'b1, 8'h61, 8'h62);
        rstN = 1'b1;
        applyStimulus(1'b1, 1'b1, 8'h61, 8'h62);
        nChecks++;
        if (gntA !== 1'b1 || gntB !== 1'b0)
            $display("[TB] FAIL post_reset_rr: got gnt_a=%b gnt_b=%b required 1 0", gntA, gntB);
        else nPass++;
    endtask

    task automatic test_random();
        logic             ra;
        logic             rb;
        logic [WIDTH-1:0] da;
        logic [WIDTH-1:0] db;
        for (int i = 0; i < 400; i++) begin
            ra = ($urandom_range(0, 3) != 0);
            rb = ($urandom_range(0, 3) != 0);
            da = WIDTH'($urandom);
            db = WIDTH'($urandom);
            applyStimulus(ra, rb, da, db);
        end
    endtask

    initial begin
        rstN  = 1'b1;
        reqA  = 1'b0;
        reqB  = 1'b0;
        dataA = '0;
        dataB = '0;
        modelReset();
        #1 rstN = 1'b0;
        test_reset();
        test_handoff();
        test_timeout();
        test_saturate();
        test_idle_hold();
        test_reset_mid_grant();
        test_random();
        @(negedge clk);
        $display("[TB] %0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
